// File: rtl/bcd_clock_segment_mux_if.sv
// ============================================================================
// Module      : bcd_clock_segment_mux_if
// Description : Control, BCD time digit and segment bus for the clock display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_clock_segment_mux_if;
  logic       en;
  logic       military_time;
  logic       set_hours;
  logic       set_minutes;
  logic [2:0] segment_select;
  logic       pm;
  logic [3:0] hours_msd;
  logic [3:0] hours_lsd;
  logic [3:0] minutes_msd;
  logic [3:0] minutes_lsd;
  logic [3:0] seconds_msd;
  logic [3:0] seconds_lsd;
  logic [6:0] led_out;

  modport master (
    output en, military_time, set_hours, set_minutes, segment_select,
    input  pm, hours_msd, hours_lsd, minutes_msd, minutes_lsd,
           seconds_msd, seconds_lsd, led_out
  );

  modport slave (
    input  en, military_time, set_hours, set_minutes, segment_select,
    output pm, hours_msd, hours_lsd, minutes_msd, minutes_lsd,
           seconds_msd, seconds_lsd, led_out
  );
endinterface

`default_nettype wire

// File: rtl/bcd_clock_segment_mux.sv
// ============================================================================
// Module      : bcd_clock_segment_mux
// Description : BCD time-of-day counter with 12/24-hour view and 7-seg mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_clock_segment_mux (
  input wire                      clk,
  input wire                      reset_n,
  bcd_clock_segment_mux_if.slave  bus
);

  localparam logic [6:0] c_seg_off = 7'h00;

  logic [3:0] r_sec_t, r_sec_u, r_min_t, r_min_u, r_hr_t, r_hr_u;

  logic [3:0] w_sec_t_inc, w_sec_u_inc, w_min_t_inc, w_min_u_inc;
  logic [3:0] w_hr_t_inc, w_hr_u_inc;
  logic       w_sec_wrap, w_min_wrap, w_hr_wrap;
  logic [4:0] w_hr_bin, w_hr_12;
  logic [3:0] w_hr_msd, w_hr_lsd, w_digit;
  logic [6:0] w_led;
  logic       w_set_any;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h7E;
      4'd1:    seg_decode = 7'h30;
      4'd2:    seg_decode = 7'h6D;
      4'd3:    seg_decode = 7'h79;
      4'd4:    seg_decode = 7'h33;
      4'd5:    seg_decode = 7'h5B;
      4'd6:    seg_decode = 7'h5F;
      4'd7:    seg_decode = 7'h70;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h7B;
      default: seg_decode = c_seg_off;
    endcase
  endfunction

  // Per-field BCD increment values with their own wrap points
  always_comb begin
    w_sec_wrap  = (r_sec_t == 4'd5) && (r_sec_u == 4'd9);
    w_min_wrap  = (r_min_t == 4'd5) && (r_min_u == 4'd9);
    w_hr_wrap   = (r_hr_t == 4'd2) && (r_hr_u == 4'd3);
    w_sec_u_inc = (r_sec_u == 4'd9) ? 4'd0 : r_sec_u + 4'd1;
    w_sec_t_inc = w_sec_wrap ? 4'd0 : ((r_sec_u == 4'd9) ? r_sec_t + 4'd1 : r_sec_t);
    w_min_u_inc = (r_min_u == 4'd9) ? 4'd0 : r_min_u + 4'd1;
    w_min_t_inc = w_min_wrap ? 4'd0 : ((r_min_u == 4'd9) ? r_min_t + 4'd1 : r_min_t);
    w_hr_u_inc  = (w_hr_wrap || r_hr_u == 4'd9) ? 4'd0 : r_hr_u + 4'd1;
    w_hr_t_inc  = w_hr_wrap ? 4'd0 : ((r_hr_u == 4'd9) ? r_hr_t + 4'd1 : r_hr_t);
  end

  assign w_set_any = bus.set_hours || bus.set_minutes;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sec_t <= 4'd0;
      r_sec_u <= 4'd0;
      r_min_t <= 4'd0;
      r_min_u <= 4'd0;
      r_hr_t  <= 4'd0;
      r_hr_u  <= 4'd0;
    end else if (w_set_any) begin
      // Setting never carries between fields and pauses normal counting
      if (bus.set_minutes) begin
        r_min_t <= w_min_t_inc;
        r_min_u <= w_min_u_inc;
        r_sec_t <= 4'd0;
        r_sec_u <= 4'd0;
      end
      if (bus.set_hours) begin
        r_hr_t <= w_hr_t_inc;
        r_hr_u <= w_hr_u_inc;
      end
    end else if (bus.en) begin
      r_sec_t <= w_sec_t_inc;
      r_sec_u <= w_sec_u_inc;
      if (w_sec_wrap) begin
        r_min_t <= w_min_t_inc;
        r_min_u <= w_min_u_inc;
        if (w_min_wrap) begin
          r_hr_t <= w_hr_t_inc;
          r_hr_u <= w_hr_u_inc;
        end
      end
    end
  end

  // 12-hour view: 0 -> 12, 13..23 -> 1..11, otherwise unchanged
  always_comb begin
    w_hr_bin = 5'(r_hr_t) * 5'd10 + 5'(r_hr_u);
    if (w_hr_bin == 5'd0)
      w_hr_12 = 5'd12;
    else if (w_hr_bin > 5'd12)
      w_hr_12 = w_hr_bin - 5'd12;
    else
      w_hr_12 = w_hr_bin;

    if (bus.military_time) begin
      w_hr_msd = r_hr_t;
      w_hr_lsd = r_hr_u;
    end else if (w_hr_12 >= 5'd10) begin
      w_hr_msd = 4'd1;
      w_hr_lsd = 4'(w_hr_12 - 5'd10);
    end else begin
      w_hr_msd = 4'd0;
      w_hr_lsd = w_hr_12[3:0];
    end
  end

  always_comb begin
    w_digit = 4'd0;
    case (bus.segment_select)
      3'd0:    w_digit = w_hr_msd;
      3'd1:    w_digit = w_hr_lsd;
      3'd2:    w_digit = r_min_t;
      3'd3:    w_digit = r_min_u;
      3'd4:    w_digit = r_sec_t;
      3'd5:    w_digit = r_sec_u;
      default: w_digit = 4'd0;
    endcase
    if (!bus.en || bus.segment_select > 3'd5)
      w_led = c_seg_off;
    else
      w_led = seg_decode(w_digit);
  end

  assign bus.pm          = !bus.military_time && (w_hr_bin >= 5'd12);
  assign bus.hours_msd   = w_hr_msd;
  assign bus.hours_lsd   = w_hr_lsd;
  assign bus.minutes_msd = r_min_t;
  assign bus.minutes_lsd = r_min_u;
  assign bus.seconds_msd = r_sec_t;
  assign bus.seconds_lsd = r_sec_u;
  assign bus.led_out     = w_led;

endmodule

`default_nettype wire

// File: tb/tb_bcd_clock_segment_mux.sv
// ============================================================================
// Module      : tb_bcd_clock_segment_mux
// Description : Scoreboard bench against a seconds-of-day reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_clock_segment_mux;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bcd_clock_segment_mux_if bus ();

  bcd_clock_segment_mux dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    int h;
    int m;
    int s;
    bit mil;
    bit en;
    int sel;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   mh = 0, mm = 0, ms = 0;
  logic [6:0] seg_tab [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  function automatic logic [31:0] expect_vec(exp_t x);
    int         dh;
    logic [3:0] dg [6];
    logic [6:0] led;
    logic       pm;
    dh    = x.mil ? x.h : ((x.h % 12 == 0) ? 12 : x.h % 12);
    pm    = !x.mil && (x.h >= 12);
    dg[0] = 4'(dh / 10);
    dg[1] = 4'(dh % 10);
    dg[2] = 4'(x.m / 10);
    dg[3] = 4'(x.m % 10);
    dg[4] = 4'(x.s / 10);
    dg[5] = 4'(x.s % 10);
    led   = (x.en && x.sel < 6) ? seg_tab[dg[x.sel]] : 7'h00;
    return {pm, dg[0], dg[1], dg[2], dg[3], dg[4], dg[5], led};
  endfunction

  task automatic compare(exp_t x, string name);
    logic [31:0] act, exp;
    act = {bus.pm, bus.hours_msd, bus.hours_lsd, bus.minutes_msd, bus.minutes_lsd,
           bus.seconds_msd, bus.seconds_lsd, bus.led_out};
    exp = expect_vec(x);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t time=%0d:%0d:%0d mil=%0d en=%0d sel=%0d got=%h want=%h",
               name, $time, x.h, x.m, x.s, x.mil, x.en, x.sel, act, exp);
    end
  endtask

  function automatic exp_t now_exp();
    exp_t x;
    x.h   = mh;
    x.m   = mm;
    x.s   = ms;
    x.mil = bus.military_time;
    x.en  = bus.en;
    x.sel = int'(bus.segment_select);
    return x;
  endfunction

  // One clock of stimulus; the model advances as that clock edge will
  task automatic step(bit e, bit mil, bit sh, bit sm, int sel);
    int t;
    @(negedge clk);
    bus.en             = e;
    bus.military_time  = mil;
    bus.set_hours      = sh;
    bus.set_minutes    = sm;
    bus.segment_select = 3'(sel);
    if (!reset_n) begin
      mh = 0; mm = 0; ms = 0;
    end else if (sh || sm) begin
      if (sm) begin
        mm = (mm + 1) % 60;
        ms = 0;
      end
      if (sh) mh = (mh + 1) % 24;
    end else if (e) begin
      t  = (mh * 3600 + mm * 60 + ms + 1) % 86400;
      mh = t / 3600;
      mm = (t / 60) % 60;
      ms = t % 60;
    end
    q.push_back('{mh, mm, ms, mil, e, sel});
  endtask

  task automatic set_time(int h, int m, int s, bit mil);
    for (int i = 0; i < 24 && mh != h; i++) step(1, mil, 1, 0, i % 8);
    for (int i = 0; i < 61 && mm != m; i++) step(1, mil, 0, 1, i % 8);
    if (ms != 0) step(1, mil, 0, 1, 0);
    for (int i = 0; i < 61 && mm != m; i++) step(1, mil, 0, 1, i % 8);
    for (int i = 0; i < s; i++) step(1, mil, 0, 0, i % 8);
  endtask

  initial begin
    forever begin
      exp_t x;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        compare(x, "scoreboard");
      end
    end
  end

  initial begin
    int k;
    bus.en = 1'b0;
    bus.military_time = 1'b1;
    bus.set_hours = 1'b0;
    bus.set_minutes = 1'b0;
    bus.segment_select = 3'd0;

    // Reset state in both hour views, with set inputs overridden by reset
    repeat (2) @(negedge clk);
    #1;
    bus.en = 1'b1;
    bus.segment_select = 3'd5;
    #1 compare(now_exp(), "reset_mil");
    bus.military_time = 1'b0;
    bus.segment_select = 3'd0;
    #1 compare(now_exp(), "reset_12h");
    step(1, 0, 1, 1, 1);
    step(1, 1, 0, 0, 3);
    @(posedge clk);
    #2 reset_n = 1'b1;

    // 60 counted seconds in 12-hour view
    for (int i = 0; i < 60; i++) step(1, 0, 0, 0, i % 8);

    // Midnight rollover in 24-hour and 12-hour views
    set_time(23, 59, 59, 1'b1);
    step(1, 1, 0, 0, 0);
    set_time(23, 59, 59, 1'b0);
    step(1, 0, 0, 0, 1);

    // Setting wraps without carrying
    set_time(0, 0, 30, 1'b1);
    for (int i = 0; i < 61; i++) step(0, 1, 0, 1, i % 8);
    for (int i = 0; i < 25; i++) step(0, 1, 1, 0, i % 8);
    step(0, 1, 1, 1, 2);

    // Digit selection at 13:45:27, then mode flips seen without a clock
    set_time(13, 45, 27, 1'b0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, i);
    @(posedge clk);
    #2 bus.military_time = 1'b1;
    bus.segment_select = 3'd1;
    #1 compare(now_exp(), "mode_flip");

    // Blanked and held
    for (int i = 0; i < 8; i++) step(0, i % 2, 0, 0, i);

    // Randomised inputs
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
           int'($urandom_range(0, 7)));

    // Asynchronous reset mid-count, observed before the next edge
    set_time(17, 38, 41, 1'b1);
    step(1, 1, 0, 0, 4);
    @(posedge clk);
    #3 reset_n = 1'b0;
    mh = 0; mm = 0; ms = 0;
    #1 compare(now_exp(), "async_reset");
    step(1, 1, 0, 0, 5);
    step(1, 0, 1, 0, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, i % 8);

    k = 0;
    while (q.size() > 0 && k < 10) begin
      @(posedge clk);
      #2 k++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
